// File: rtl/pc_ctrl.sv
// Fetch-PC controller: owns the PC, EPC and exception level, and selects the
// next fetch address from decode control flow, exceptions and eret.
module pc_ctrl #(
  parameter int unsigned      WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_PC    = 32'h0000_3000,
  parameter logic [WIDTH-1:0] EXC_VECTOR  = 32'h0000_4180,
  parameter bit               ALIGN_CHECK = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [WIDTH-1:0] d_pc,
  input  logic             d_valid,
  input  logic             jal,
  input  logic             jr,
  input  logic             beq,
  input  logic             iseq,
  input  logic [25:0]      imm26,
  input  logic [15:0]      imm16,
  input  logic [WIDTH-1:0] drs,
  input  logic             exc_req,
  input  logic [WIDTH-1:0] exc_epc,
  input  logic             eret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] npc,
  output logic [WIDTH-1:0] epc,
  output logic             exl,
  output logic             redirect,
  output logic             fetch_misalign
);

  localparam int unsigned EXT_W = WIDTH - 18;

  typedef enum logic {
    NORMAL  = 1'b0,
    HANDLER = 1'b1
  } mode_t;

  mode_t            mode_q, mode_d;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             redirect_q, redirect_d;

  logic [WIDTH-1:0] jump_tgt;
  logic [WIDTH-1:0] br_off;
  logic [WIDTH-1:0] br_tgt;

  // Decode-stage targets; the delay slot is never squashed here.
  assign jump_tgt = {d_pc[WIDTH-1:28], imm26, 2'b00};
  assign br_off   = {{EXT_W{imm16[15]}}, imm16, 2'b00};
  assign br_tgt   = d_pc + WIDTH'(4) + br_off;
  assign pc_plus4 = pc_q + WIDTH'(4);

  // State registers; reset is asynchronous.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q     <= NORMAL;
      pc_q       <= RESET_PC;
      epc_q      <= '0;
      redirect_q <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      pc_q       <= npc;
      epc_q      <= epc_d;
      redirect_q <= redirect_d;
    end
  end

  // Strict-priority next-PC selection; exception and eret override stall.
  always_comb begin
    mode_d     = mode_q;
    epc_d      = epc_q;
    redirect_d = 1'b0;
    npc        = pc_plus4;
    if (exc_req) begin
      npc        = EXC_VECTOR;
      mode_d     = HANDLER;
      redirect_d = 1'b1;
      if (mode_q == NORMAL) begin
        epc_d = exc_epc;
      end
    end else if (eret) begin
      npc        = epc_q;
      mode_d     = NORMAL;
      redirect_d = 1'b1;
    end else if (stall) begin
      npc = pc_q;
    end else if (d_valid && jal) begin
      npc        = jump_tgt;
      redirect_d = 1'b1;
    end else if (d_valid && jr) begin
      npc        = drs;
      redirect_d = 1'b1;
    end else if (d_valid && beq && iseq) begin
      npc        = br_tgt;
      redirect_d = 1'b1;
    end
  end

  assign pc       = pc_q;
  assign epc      = epc_q;
  assign exl      = (mode_q == HANDLER);
  assign redirect = redirect_q;

  generate
    if (ALIGN_CHECK) begin : g_align
      assign fetch_misalign = |pc_q[1:0];
    end else begin : g_noalign
      assign fetch_misalign = 1'b0;
    end
  endgenerate

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Parametrised fetch-PC controller for the pipelined MIPS core. It owns the PC register and computes the next PC from the decode-stage control-flow fields: j/jal, jr and beq, with a delay slot. It also handles exception entry and eret through an internal EPC register and an exception-level flag. It sits between the fetch stage (driving the IM address) and the decode/hazard/CP0 logic.

## Interface
- WIDTH, 32, PC and data width; must be ≥ 32 (jump target uses bits [27:0] from imm26).
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_4180, handler entry address.
- ALIGN_CHECK, 1, 1 enables the fetch_misalign output; 0 ties it to 0.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- stall  in  1  hazard unit hold; PC and decode redirect frozen.
- d_pc  in  WIDTH  PC of the instruction in decode.
- d_valid  in  1  decode instruction is real (not a bubble).
- jal  in  1  j or jal in decode.
- jr  in  1  jr or jalr in decode.
- beq  in  1  branch in decode.
- iseq  in  1  branch condition true.
- imm26  in  26  jump index.
- imm16  in  16  branch offset.
- drs  in  WIDTH  forwarded GPR[rs].
- exc_req  in  1  synchronous exception/interrupt taken by the pipeline this cycle.
- exc_epc  in  WIDTH  restart address for that exception.
- eret  in  1  eret committed this cycle.
- pc  out  WIDTH  current fetch PC.
- pc_plus4  out  WIDTH  pc + 4.
- npc  out  WIDTH  combinational next PC.
- epc  out  WIDTH  saved restart address.
- exl  out  1  exception level; 1 while in handler.
- redirect  out  1  registered; 1 for one cycle after a non-sequential PC load.
- fetch_misalign  out  1  pc[1:0] != 0 (when ALIGN_CHECK=1).

## Operation
- The state is pc, epc and exl. There are two modes: NORMAL (exl=0) and HANDLER (exl=1).
- Reset values: pc=RESET_PC, epc=0, exl=0, redirect=0. The reset takes effect asynchronously, without waiting for a clock edge.
- npc is chosen by strict priority. The first matching row wins:
  1. exc_req: npc=EXC_VECTOR. epc:=exc_epc only if exl=0; epc is unchanged if exl=1. exl:=1.
  2. eret: npc=epc, exl:=0.
  3. stall: npc=pc. No state changes.
  4. d_valid & jal: npc={d_pc[WIDTH-1:28], imm26, 2'b00}.
  5. d_valid & jr: npc=drs.
  6. d_valid & beq & iseq: npc=d_pc + 4 + (sign-extend(imm16) << 2).
  7. Otherwise: npc=pc+4.
- The fetch PC at the time of a decode redirect is the delay slot (d_pc+4). That slot always executes; this block never squashes it.
- All arithmetic is modulo 2^WIDTH. Overflow wraps silently; 0xFFFF_FFFC + 4 = 0.
- If jal, jr and beq are asserted together (illegal decode), row order decides: jal beats jr beats beq.
- exc_req and eret in the same cycle: the exception wins and eret is dropped.
- redirect:=1 whenever rows 1, 2, 4, 5 or 6 load the PC; otherwise redirect:=0.
- fetch_misalign is purely combinational on pc. This block does not raise the exception itself; CP0 raises it via exc_req.

## Timing
- pc, epc, exl and redirect update on the rising clk edge. npc and pc_plus4 are combinational from the current inputs and state.
- Redirect latency: the target appears on pc at the edge after the decode control is seen, provided stall=0.
- A stall held for N cycles keeps pc constant for N edges, and any pending decode redirect is re-evaluated afterwards. Exception and eret override stall in the same cycle.
- Reset asserted mid-operation forces the reset values immediately. The first edge after reset deasserts loads npc computed from RESET_PC.

## Test plan
- Sequential fetch: release reset, no controls for 3 edges → pc = 0x3000, 0x3004, 0x3008, 0x300C; redirect=0 throughout.
- Branch taken plus stall: d_pc=0x3010, beq=iseq=1, imm16=0xFFFC, first with stall=1 for 2 cycles, then stall=0 → pc holds for 2 cycles, then becomes 0x3004 with redirect=1. Repeat with iseq=0 → pc=pc+4.
- Jumps: jal with d_pc=0x3020, imm26=0x0000C10 → pc=0x3040. jr with drs=0x3100 → pc=0x3100. All three decode controls asserted together → jal target is taken.
- Exception and eret: exc_req with exc_epc=0x3050 → pc=0x4180, epc=0x3050, exl=1. A second exc_req while exl=1 with exc_epc=0x4188 → pc=0x4180 and epc stays 0x3050. eret → pc=0x3050, exl=0.
- Simultaneous events and wrap: exc_req, eret and stall together → exception taken, exl=1. With pc=0xFFFF_FFFC and no controls → pc=0x0000_0000.
- Reset and misalign: assert reset between edges while pc=0x4180 → pc=0x3000 immediately, exl=0. jr to drs=0x3002 → fetch_misalign=1 next cycle.
